// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory pair sequencer.
// State encoding, word width and word-aligned address helper.
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ1  = 3'd1,
    WAIT1 = 3'd2,
    REQ2  = 3'd3,
    WAIT2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] byte_addr);
    return byte_addr & {{(WORD_W-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_pair_sequencer.sv
// Issues up to two M-stage memory operations in program order over one
// request/grant/response port, stalling the pipeline until both complete.
module dmem_pair_sequencer
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_M,
  input  logic              MemWrite_M,
  input  logic [WORD_W-1:0] ALUOut_M,
  input  logic [WORD_W-1:0] WriteData_M,
  input  logic              MemRead_M2,
  input  logic              MemWrite_M2,
  input  logic [WORD_W-1:0] ALUOut_M2,
  input  logic [WORD_W-1:0] WriteData_M2,
  output logic              Stall_M,
  output logic [WORD_W-1:0] ReadData_M,
  output logic [WORD_W-1:0] ReadData_M2,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata
);

  state_t state, state_nxt;
  logic   slot1_act, slot2_act;
  logic   stall_raw;

  // A store takes priority when both read and write are set in a slot.
  assign slot1_act = MemRead_M  | MemWrite_M;
  assign slot2_act = MemRead_M2 | MemWrite_M2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (slot1_act)      state_nxt = REQ1;
        else if (slot2_act) state_nxt = REQ2;
      end
      REQ1: begin
        if (mem_gnt) begin
          if (!MemWrite_M)    state_nxt = WAIT1;
          else if (slot2_act) state_nxt = REQ2;
          else                state_nxt = DONE;
        end
      end
      WAIT1: begin
        if (mem_rvalid) state_nxt = slot2_act ? REQ2 : DONE;
      end
      REQ2: begin
        if (mem_gnt) state_nxt = MemWrite_M2 ? DONE : WAIT2;
      end
      WAIT2: begin
        if (mem_rvalid) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot mux: the bus carries the active slot only while requesting.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall_raw = 1'b0;
    case (state)
      IDLE: stall_raw = slot1_act | slot2_act;
      REQ1: begin
        stall_raw = 1'b1;
        mem_req   = 1'b1;
        mem_we    = MemWrite_M;
        mem_addr  = word_addr(ALUOut_M);
        mem_wdata = WriteData_M;
      end
      REQ2: begin
        stall_raw = 1'b1;
        mem_req   = 1'b1;
        mem_we    = MemWrite_M2;
        mem_addr  = word_addr(ALUOut_M2);
        mem_wdata = WriteData_M2;
      end
      WAIT1, WAIT2: stall_raw = 1'b1;
      default: ;
    endcase
  end

  assign Stall_M = stall_raw & ~reset;

  // Load results persist until the next load in the same slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ReadData_M  <= '0;
      ReadData_M2 <= '0;
    end else begin
      if (state == WAIT1 && mem_rvalid) ReadData_M  <= mem_rdata;
      if (state == WAIT2 && mem_rvalid) ReadData_M2 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_pair_sequencer.sv
// Bench for dmem_pair_sequencer: directed cases plus randomized bundles
// against a transaction-level model of program-order memory semantics.
module tb_dmem_pair_sequencer;

  logic        clk;
  logic        reset;
  logic        MemRead_M, MemWrite_M, MemRead_M2, MemWrite_M2;
  logic [31:0] ALUOut_M, WriteData_M, ALUOut_M2, WriteData_M2;
  logic        Stall_M;
  logic [31:0] ReadData_M, ReadData_M2;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  dmem_pair_sequencer dut (
    .clk(clk), .reset(reset),
    .MemRead_M(MemRead_M), .MemWrite_M(MemWrite_M),
    .ALUOut_M(ALUOut_M), .WriteData_M(WriteData_M),
    .MemRead_M2(MemRead_M2), .MemWrite_M2(MemWrite_M2),
    .ALUOut_M2(ALUOut_M2), .WriteData_M2(WriteData_M2),
    .Stall_M(Stall_M), .ReadData_M(ReadData_M), .ReadData_M2(ReadData_M2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Backing memory: 64 words, unwritten words read a fixed address pattern.
  logic        mem_clr;
  int          gnt_dly, rv_dly;
  int          req_cnt, rd_cnt;
  logic [31:0] rd_buf;
  logic [31:0] mem_store [64];
  logic        written   [64];

  function automatic logic [31:0] dflt(input int w);
    return 32'hC0DE_0000 | w;
  endfunction

  function automatic logic [31:0] lookup(input logic [31:0] a);
    return written[a[7:2]] ? mem_store[a[7:2]] : dflt(int'(a[7:2]));
  endfunction

  assign mem_gnt = mem_req && (req_cnt >= gnt_dly);

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) written[i] <= 1'b0;
      rd_cnt     <= 0;
      req_cnt    <= 0;
      rd_buf     <= '0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      mem_rvalid <= 1'b0;
      if (rd_cnt == 1) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= rd_buf;
      end
      if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
      if (mem_req && mem_gnt) begin
        req_cnt <= 0;
        if (mem_we) begin
          mem_store[mem_addr[7:2]] <= mem_wdata;
          written[mem_addr[7:2]]   <= 1'b1;
        end else if (rv_dly == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= lookup(mem_addr);
        end else begin
          rd_cnt <= rv_dly - 1;
          rd_buf <= lookup(mem_addr);
        end
      end else if (mem_req) begin
        req_cnt <= req_cnt + 1;
      end else begin
        req_cnt <= 0;
      end
    end
  end

  // Reference model: ordered transaction list and program-order memory image.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q [$];
  logic [31:0] ref_mem [64];
  logic [31:0] exp_rd1, exp_rd2;

  task automatic model_slot(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input bit slot2);
    txn_t t;
    int   wi;
    wi = int'(a[7:2]);
    if (!(r || w)) return;
    t.we    = w;
    t.addr  = (a / 4) * 4;
    t.wdata = w ? d : 32'h0;
    exp_q.push_back(t);
    if (w) ref_mem[wi] = d;
    else if (slot2) exp_rd2 = ref_mem[wi];
    else exp_rd1 = ref_mem[wi];
  endtask

  task automatic run_bundle(input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                            input logic r2, input logic w2, input logic [31:0] a2, input logic [31:0] d2,
                            output int cyc);
    MemRead_M  = r1; MemWrite_M  = w1; ALUOut_M  = a1; WriteData_M  = d1;
    MemRead_M2 = r2; MemWrite_M2 = w2; ALUOut_M2 = a2; WriteData_M2 = d2;
    model_slot(r1, w1, a1, d1, 1'b0);
    model_slot(r2, w2, a2, d2, 1'b1);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (Stall_M && cyc < 300);
    check("bundle_done", {31'b0, Stall_M}, 32'h0);
    check("rd_slot1", ReadData_M, exp_rd1);
    check("rd_slot2", ReadData_M2, exp_rd2);
    check("txn_all_issued", exp_q.size(), 32'h0);
    if (!(r1 || w1 || r2 || w2)) check("idle_bundle_len", cyc, 32'd1);
    @(posedge clk);
    #1;
    MemRead_M  = 0; MemWrite_M  = 0; ALUOut_M  = 0; WriteData_M  = 0;
    MemRead_M2 = 0; MemWrite_M2 = 0; ALUOut_M2 = 0; WriteData_M2 = 0;
  endtask

  // Per-cycle bus checker: idle bus values, request stability, order/contents.
  initial begin : bus_cmp
    logic        hold;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    txn_t        t;
    hold = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else if (!mem_req) begin
        check("bus_idle_zero", {31'b0, mem_we} | mem_addr | mem_wdata, 32'h0);
        hold = 1'b0;
      end else begin
        check("one_outstanding", {31'b0, rd_cnt != 0}, 32'h0);
        if (hold) begin
          check("hold_we", {31'b0, mem_we}, {31'b0, h_we});
          check("hold_addr", mem_addr, h_addr);
          check("hold_wdata", mem_wdata, h_wdata);
        end
        if (mem_gnt) begin
          hold = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_req", 32'h1, 32'h0);
          end else begin
            t = exp_q.pop_front();
            check("txn_we", {31'b0, mem_we}, {31'b0, t.we});
            check("txn_addr", mem_addr, t.addr);
            if (t.we) check("txn_wdata", mem_wdata, t.wdata);
          end
        end else begin
          hold = 1'b1; h_we = mem_we; h_addr = mem_addr; h_wdata = mem_wdata;
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cyc;
    logic r1, w1, r2, w2;
    logic [31:0] a1, a2, d1, d2;
    int k;

    for (int i = 0; i < 64; i++) ref_mem[i] = dflt(i);
    exp_rd1 = '0; exp_rd2 = '0;
    mem_clr = 1'b1; gnt_dly = 0; rv_dly = 1;
    reset = 1'b1;
    MemRead_M  = 0; MemWrite_M  = 1; ALUOut_M  = 32'h10; WriteData_M  = 32'h1111_2222;
    MemRead_M2 = 0; MemWrite_M2 = 0; ALUOut_M2 = 0;      WriteData_M2 = 0;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;

    // Reset with a slot-1 store pending
    @(negedge clk);
    check("rst_stall", {31'b0, Stall_M}, 32'h0);
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_we", {31'b0, mem_we}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_rd1", ReadData_M, 32'h0);
    check("rst_rd2", ReadData_M2, 32'h0);
    model_slot(1'b0, 1'b1, 32'h10, 32'h1111_2222, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle_stall", {31'b0, Stall_M}, 32'h1);
    check("post_rst_idle_req", {31'b0, mem_req}, 32'h0);
    @(negedge clk);
    check("req1_req", {31'b0, mem_req}, 32'h1);
    check("req1_addr", mem_addr, 32'h10);
    check("req1_we", {31'b0, mem_we}, 32'h1);
    @(negedge clk);
    check("done_stall", {31'b0, Stall_M}, 32'h0);
    @(posedge clk);
    #1 MemWrite_M = 0; ALUOut_M = 0; WriteData_M = 0;

    // Reset during WAIT1; the late response must be ignored
    rv_dly = 3;
    MemRead_M = 1; ALUOut_M = 32'h30;
    begin
      txn_t t;
      t.we = 1'b0; t.addr = 32'h30; t.wdata = 32'h0;
      exp_q.push_back(t);
    end
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("wait1_stall", {31'b0, Stall_M}, 32'h1);
    check("wait1_req", {31'b0, mem_req}, 32'h0);
    #1 reset = 1'b1;
    MemRead_M = 0; ALUOut_M = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stray_rv_stall", {31'b0, Stall_M}, 32'h0);
      check("stray_rv_req", {31'b0, mem_req}, 32'h0);
      check("stray_rv_rd1", ReadData_M, 32'h0);
    end
    @(posedge clk);
    #1;

    // Minimum latencies
    gnt_dly = 0; rv_dly = 1;
    run_bundle(0, 1, 32'h44, 32'h0000_000A, 0, 0, 0, 0, cyc);
    check("lat_one_store", cyc, 32'd3);
    run_bundle(1, 0, 32'h48, 0, 0, 0, 0, 0, cyc);
    check("lat_one_load", cyc, 32'd4);
    check("lat_one_load_data", ReadData_M, 32'hC0DE_0012);
    run_bundle(1, 0, 32'h50, 0, 1, 0, 32'h54, 0, cyc);
    check("lat_two_loads", cyc, 32'd6);

    // Store then load of the same word, slow memory
    gnt_dly = 2; rv_dly = 3;
    run_bundle(0, 1, 32'h20, 32'hDEAD_BEEF, 1, 0, 32'h20, 0, cyc);
    check("st_ld_same_word", ReadData_M2, 32'hDEAD_BEEF);
    check("st_ld_cycles", cyc, 32'd11);

    // Idle bundles
    for (int i = 0; i < 5; i++) run_bundle(0, 0, 0, 0, 0, 0, 0, 0, cyc);

    // Slot 2 only, unaligned address
    gnt_dly = 1; rv_dly = 2;
    run_bundle(0, 0, 0, 0, 1, 0, 32'h7, 0, cyc);
    check("slot2_only_rd2", ReadData_M2, 32'hC0DE_0001);
    check("slot2_only_rd1_kept", ReadData_M, 32'hC0DE_0014);

    // Read and write both set: store only
    gnt_dly = 0; rv_dly = 1;
    run_bundle(1, 1, 32'h40, 32'h1234_5678, 0, 0, 0, 0, cyc);
    check("rw_both_is_store", cyc, 32'd3);
    run_bundle(1, 0, 32'h40, 0, 0, 0, 0, 0, cyc);
    check("rw_both_readback", ReadData_M, 32'h1234_5678);

    // Randomized bundles
    for (int n = 0; n < 250; n++) begin
      gnt_dly = $urandom_range(0, 3);
      rv_dly  = $urandom_range(1, 4);
      k = $urandom_range(0, 3); r1 = k[0]; w1 = k[1];
      k = $urandom_range(0, 3); r2 = k[0]; w2 = k[1];
      a1 = $urandom_range(0, 255);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 32'($urandom_range(0, 255));
      d1 = $urandom;
      d2 = $urandom;
      run_bundle(r1, w1, a1, d1, r2, w2, a2, d2, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
